// File: rtl/serial_comparator_pkg.sv
// rtl/serial_comparator_pkg.sv - shared state encodings and result bit order for serial_comparator
package serial_comparator_pkg;

    // Controller states; encodings are shared with the bench.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Result vector bit order is {greater, less, equal}.
    localparam int RES_EQ = 0;
    localparam int RES_LT = 1;
    localparam int RES_GT = 2;
    localparam int RES_W  = 3;

endpackage

// File: rtl/serial_comparator_digit_compare.sv
// rtl/serial_comparator_digit_compare.sv - combinational unsigned compare of one DIGIT-bit slice
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    // Exactly one of eq/lt/gt is set for any pair of slices.
    always_comb begin
        eq = (a == b);
        lt = (a < b);
        gt = (a > b);
    end

endmodule

// File: rtl/serial_comparator.sv
// rtl/serial_comparator.sv - MSB-first digit-serial magnitude/equality comparator with early exit
module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             is_signed,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             equal,
    output logic             less,
    output logic             greater
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx_q;
    logic [RES_W-1:0] result_q;
    logic [WIDTH-1:0] sign_mask;
    logic             dig_eq;
    logic             dig_lt;
    logic             dig_gt;
    logic             last_digit;

    // Flipping the sign bit of both operands turns a two's-complement
    // compare into an unsigned compare of the modified values.
    assign sign_mask  = {is_signed, {(WIDTH-1){1'b0}}};
    assign last_digit = (idx_q == LAST_IDX);

    assign equal   = result_q[RES_EQ];
    assign less    = result_q[RES_LT];
    assign greater = result_q[RES_GT];

    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit_compare (
        .a  (a_q[WIDTH-1 -: DIGIT]),
        .b  (b_q[WIDTH-1 -: DIGIT]),
        .eq (dig_eq),
        .lt (dig_lt),
        .gt (dig_gt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; the top digit decides or we move on.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (!dig_eq || last_digit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand shift registers, digit index and registered result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        a_q   <= in0 ^ sign_mask;
                        b_q   <= in1 ^ sign_mask;
                        idx_q <= '0;
                    end
                end
                S_COMPARE: begin
                    if (!dig_eq) begin
                        result_q[RES_EQ] <= 1'b0;
                        result_q[RES_LT] <= dig_lt;
                        result_q[RES_GT] <= dig_gt;
                    end else if (last_digit) begin
                        result_q[RES_EQ] <= 1'b1;
                        result_q[RES_LT] <= 1'b0;
                        result_q[RES_GT] <= 1'b0;
                    end else begin
                        a_q   <= a_q << DIGIT;
                        b_q   <= b_q << DIGIT;
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// tb/tb_serial_comparator.sv - self-checking bench for serial_comparator
module tb_serial_comparator;
    import serial_comparator_pkg::*;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             is_signed;
    logic             req_valid;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             equal;
    logic             less;
    logic             greater;

    int checks   = 0;
    int failures = 0;

    serial_comparator #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in0       (in0),
        .in1       (in1),
        .is_signed (is_signed),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .equal     (equal),
        .less      (less),
        .greater   (greater)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sgn;
        logic [RES_W-1:0] res;
        int               lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RES_W-1:0] cur_res();
        logic [RES_W-1:0] r;
        r         = '0;
        r[RES_EQ] = equal;
        r[RES_LT] = less;
        r[RES_GT] = greater;
        return r;
    endfunction

    // Reference: relation from plain (signed or unsigned) arithmetic, latency
    // from the position of the most significant differing bit.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn,
                         output logic [RES_W-1:0] res, output int lat);
        logic [WIDTH-1:0] x;
        int msb;
        res = '0;
        if (a == b) res[RES_EQ] = 1'b1;
        else if (sgn ? ($signed(a) < $signed(b)) : (a < b)) res[RES_LT] = 1'b1;
        else res[RES_GT] = 1'b1;
        x   = a ^ b;
        msb = -1;
        for (int i = 0; i < WIDTH; i++) if (x[i]) msb = i;
        lat = (msb < 0) ? NDIG : ((WIDTH - 1 - msb) / DIGIT + 1);
    endtask

    // One full transaction: accept, wait for result, optional backpressure, handshake.
    task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sgn, input logic [RES_W-1:0] exp_res, input int exp_lat,
                         input int hold);
        int lat;
        logic [RES_W-1:0] got;
        @(negedge clk);
        check({name, "_req_ready"}, req_ready, 1);
        in0 = a; in1 = b; is_signed = sgn; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        in0 = $urandom; in1 = $urandom; is_signed = ~sgn;
        lat = 0;
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_rsp_valid"}, rsp_valid, 1);
        check({name, "_latency"}, lat, exp_lat);
        got = cur_res();
        check({name, "_result"}, got, exp_res);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, rsp_valid, 1);
            check({name, "_hold_result"}, cur_res(), got);
            check({name, "_hold_req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_post_valid"}, rsp_valid, 0);
        check({name, "_post_req_ready"}, req_ready, 1);
    endtask

    vec_t vecs[9];

    initial begin
        logic [RES_W-1:0] er;
        int               el;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        bit               seen;

        vecs[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b001, 8};
        vecs[1] = '{32'h10000000, 32'h00000000, 1'b0, 3'b100, 1};
        vecs[2] = '{32'h00000005, 32'h00000006, 1'b0, 3'b010, 8};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 1};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b010, 1};
        vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b010, 1};
        vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 3'b010, 1};
        vecs[7] = '{32'h12345678, 32'h12345478, 1'b0, 3'b100, 6};
        vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3'b001, 8};

        // Reset with a pending request: nothing may be accepted.
        reset_n = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
        in0 = 32'h1; in1 = 32'h2; is_signed = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_result", cur_res(), 0);
        req_valid = 1'b0;
        reset_n   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_no_accept", req_ready, 1);
        check("reset_no_rsp", rsp_valid, 0);

        // Directed table.
        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].res, vecs[i].lat, 0);

        // Backpressure: result held for 5 cycles with a request knocking.
        @(negedge clk);
        in0 = 32'h00000005; in1 = 32'h00000006; is_signed = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (NDIG) @(negedge clk);
        check("bp_valid", rsp_valid, 1);
        check("bp_result", cur_res(), 3'b010);
        req_valid = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_result", cur_res(), 3'b010);
            check("bp_hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("bp_after_valid", rsp_valid, 0);
        check("bp_after_req_ready", req_ready, 1);
        @(negedge clk);
        check("bp_no_accept", req_ready, 1);

        // rsp_ready held high ahead of DONE has no effect on the decision.
        rsp_ready = 1'b1;
        in0 = 32'h10000000; in1 = 32'h0; is_signed = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("early_ready_busy", rsp_valid, 0);
        @(negedge clk);
        check("early_ready_valid", rsp_valid, 1);
        check("early_ready_result", cur_res(), 3'b100);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("early_ready_taken", rsp_valid, 0);
        check("early_ready_idle", req_ready, 1);

        // Abort mid-compare: the operation never reports.
        in0 = 32'hDEADBEEF; in1 = 32'hDEADBEEF; is_signed = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy", req_ready, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_idle", req_ready, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_result", cur_res(), 0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_never_valid", seen, 0);

        // Randomized operands against the reference model.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = $urandom;
                2:       rb = ra ^ (32'h1 << $urandom_range(0, WIDTH - 1));
                default: rb = ra ^ ($urandom & 32'h0000FFFF);
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, er, el);
            do_op($sformatf("rnd%0d", i), ra, rb, rs, er, el, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
